// File: rtl/pe_input_feeder.sv
// rtl/pe_input_feeder.sv - unpacks GLB words into a PE pixel stream with optional zero padding.
// Optional padding ports and states are enabled by defining PE_FEEDER_ZPAD_EN.
module pe_input_feeder #(
  parameter int DW   = 16,
  parameter int NPIX = 4,
  parameter int CNTW = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_start,
  input  logic                 i_abort,
  input  logic [CNTW-1:0]      i_npix,
`ifdef PE_FEEDER_ZPAD_EN
  input  logic [3:0]           i_padL,
  input  logic [3:0]           i_padR,
`endif
  input  logic                 GLB_rdy,
  output logic                 GLB_ack,
  input  logic [DW*NPIX-1:0]   GLB_data,
  output logic                 Input_rdy,
  input  logic                 Input_ack,
  output logic [DW-1:0]        Input_data,
  output logic                 o_busy,
  output logic                 o_done
);

  localparam int SELW = (NPIX > 1) ? $clog2(NPIX) : 1;
  localparam int LOGN = $clog2(NPIX);
  localparam int WAW  = CNTW - LOGN + 1;
  localparam int WW   = DW * NPIX;

  typedef enum logic [2:0] {IDLE, PADL, STREAM, PADR, DONE} state_t;

  state_t          state_q, state_d;
  logic [CNTW-1:0] npix_q, npix_d;
  logic [CNTW-1:0] pad_cnt_q, pad_cnt_d;
  logic [CNTW-1:0] pix_cnt_q, pix_cnt_d;
  logic [WAW-1:0]  words_q, words_d;
  logic [SELW-1:0] sel_q, sel_d;
  logic [WW-1:0]   mem_q [2];
  logic [WW-1:0]   mem_d [2];
  logic            rd_ptr_q, rd_ptr_d;
  logic            wr_ptr_q, wr_ptr_d;
  logic [1:0]      count_q, count_d;

  logic [3:0]      padl_cfg, padr_cfg, start_padl, start_padr;

`ifdef PE_FEEDER_ZPAD_EN
  logic [3:0] padl_q, padl_d, padr_q, padr_d;
  assign padl_cfg   = padl_q;
  assign padr_cfg   = padr_q;
  assign start_padl = i_padL;
  assign start_padr = i_padR;
`else
  assign padl_cfg   = 4'd0;
  assign padr_cfg   = 4'd0;
  assign start_padl = 4'd0;
  assign start_padr = 4'd0;
`endif

  logic [CNTW:0]   npix_round;
  logic [WAW-1:0]  words_needed;
  logic            fifo_full, fifo_empty;
  logic [WW-1:0]   head;
  logic            glb_xfer, in_xfer, push, pop;
  logic            pad_last, pix_last, start_acc;
  logic [CNTW-1:0] pad_target;

  // Words needed per pass = ceil(npix / NPIX)
  assign npix_round   = {1'b0, npix_q} + (CNTW+1)'(NPIX - 1);
  assign words_needed = WAW'(npix_round >> LOGN);
  assign fifo_full    = (count_q == 2'd2);
  assign fifo_empty   = (count_q == 2'd0);
  assign head         = mem_q[rd_ptr_q];

  assign glb_xfer   = GLB_ack && GLB_rdy;
  assign in_xfer    = Input_rdy && Input_ack;
  assign pad_target = (state_q == PADR) ? CNTW'(padr_cfg) : CNTW'(padl_cfg);
  assign pad_last   = (pad_cnt_q == pad_target - CNTW'(1));
  assign pix_last   = (pix_cnt_q == npix_q - CNTW'(1));
  assign start_acc  = (state_q == IDLE) && i_start && !i_abort;
  assign push       = glb_xfer;
  assign pop        = (state_q == STREAM) && in_xfer &&
                      ((sel_q == SELW'(NPIX - 1)) || pix_last);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Zero-length phases are skipped in the same cycle they would be entered
  always_comb begin
    state_d = state_q;
    if (i_abort) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: if (i_start) begin
          if (start_padl != 4'd0)       state_d = PADL;
          else if (i_npix != '0)        state_d = STREAM;
          else if (start_padr != 4'd0)  state_d = PADR;
          else                          state_d = DONE;
        end
        PADL: if (in_xfer && pad_last) begin
          if (npix_q != '0)             state_d = STREAM;
          else if (padr_cfg != 4'd0)    state_d = PADR;
          else                          state_d = DONE;
        end
        STREAM: if (in_xfer && pix_last)
          state_d = (padr_cfg != 4'd0) ? PADR : DONE;
        PADR: if (in_xfer && pad_last) state_d = DONE;
        DONE: state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    GLB_ack    = 1'b0;
    Input_rdy  = 1'b0;
    Input_data = '0;
    o_busy     = (state_q != IDLE);
    o_done     = (state_q == DONE);
    case (state_q)
      PADL: begin
        Input_rdy = 1'b1;
        GLB_ack   = !fifo_full && (words_q < words_needed);
      end
      STREAM: begin
        Input_rdy  = !fifo_empty;
        Input_data = head[sel_q*DW +: DW];
        GLB_ack    = !fifo_full && (words_q < words_needed);
      end
      PADR: Input_rdy = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    npix_d    = npix_q;
    pad_cnt_d = pad_cnt_q;
    pix_cnt_d = pix_cnt_q;
    words_d   = words_q;
    sel_d     = sel_q;
    mem_d     = mem_q;
    rd_ptr_d  = rd_ptr_q;
    wr_ptr_d  = wr_ptr_q;
    count_d   = count_q;
`ifdef PE_FEEDER_ZPAD_EN
    padl_d    = padl_q;
    padr_d    = padr_q;
`endif
    if (i_abort || state_q == DONE) begin
      pad_cnt_d = '0;
      pix_cnt_d = '0;
      words_d   = '0;
      sel_d     = '0;
      rd_ptr_d  = 1'b0;
      wr_ptr_d  = 1'b0;
      count_d   = 2'd0;
    end else begin
      if (start_acc) begin
        npix_d = i_npix;
`ifdef PE_FEEDER_ZPAD_EN
        padl_d = i_padL;
        padr_d = i_padR;
`endif
      end
      if ((state_q == PADL || state_q == PADR) && in_xfer)
        pad_cnt_d = pad_last ? '0 : pad_cnt_q + CNTW'(1);
      if (state_q == STREAM && in_xfer) begin
        pix_cnt_d = pix_cnt_q + CNTW'(1);
        sel_d     = pop ? '0 : sel_q + SELW'(1);
      end
      if (push) begin
        mem_d[wr_ptr_q] = GLB_data;
        wr_ptr_d        = ~wr_ptr_q;
        words_d         = words_q + WAW'(1);
      end
      if (pop) rd_ptr_d = ~rd_ptr_q;
      case ({push, pop})
        2'b10:   count_d = count_q + 2'd1;
        2'b01:   count_d = count_q - 2'd1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      npix_q    <= '0;
      pad_cnt_q <= '0;
      pix_cnt_q <= '0;
      words_q   <= '0;
      sel_q     <= '0;
      mem_q[0]  <= '0;
      mem_q[1]  <= '0;
      rd_ptr_q  <= 1'b0;
      wr_ptr_q  <= 1'b0;
      count_q   <= 2'd0;
`ifdef PE_FEEDER_ZPAD_EN
      padl_q    <= 4'd0;
      padr_q    <= 4'd0;
`endif
    end else begin
      npix_q    <= npix_d;
      pad_cnt_q <= pad_cnt_d;
      pix_cnt_q <= pix_cnt_d;
      words_q   <= words_d;
      sel_q     <= sel_d;
      mem_q[0]  <= mem_d[0];
      mem_q[1]  <= mem_d[1];
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      count_q   <= count_d;
`ifdef PE_FEEDER_ZPAD_EN
      padl_q    <= padl_d;
      padr_q    <= padr_d;
`endif
    end
  end

endmodule

// File: tb/tb_pe_input_feeder.sv
// tb/tb_pe_input_feeder.sv - directed table-driven bench for pe_input_feeder.
module tb_pe_input_feeder;
  localparam int DW = 16, NPIX = 4, CNTW = 8;

  logic                i_clk = 1'b0;
  logic                i_rst_n, i_start, i_abort;
  logic [CNTW-1:0]     i_npix;
`ifdef PE_FEEDER_ZPAD_EN
  logic [3:0]          i_padL, i_padR;
`endif
  logic                GLB_rdy, GLB_ack;
  logic [DW*NPIX-1:0]  GLB_data;
  logic                Input_rdy, Input_ack;
  logic [DW-1:0]       Input_data;
  logic                o_busy, o_done;

  always #5 i_clk = ~i_clk;

  pe_input_feeder #(.DW(DW), .NPIX(NPIX), .CNTW(CNTW)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(i_start), .i_abort(i_abort),
    .i_npix(i_npix),
`ifdef PE_FEEDER_ZPAD_EN
    .i_padL(i_padL), .i_padR(i_padR),
`endif
    .GLB_rdy(GLB_rdy), .GLB_ack(GLB_ack), .GLB_data(GLB_data),
    .Input_rdy(Input_rdy), .Input_ack(Input_ack), .Input_data(Input_data),
    .o_busy(o_busy), .o_done(o_done)
  );

  typedef struct {
    int npix; int base; int glb_mask; int ack_mask; int stall;
    int padl; int padr; int exp_words; int exp_xfers; int exp_stall_words; int nobubble;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [DW*NPIX-1:0] make_word(input int base, input int w);
    logic [DW*NPIX-1:0] r;
    for (int l = 0; l < NPIX; l++) r[l*DW +: DW] = 16'(base + w*NPIX + l);
    return r;
  endfunction

  function automatic logic [DW-1:0] exp_pix(input int k, input int base, input int padl, input int npix);
    if (k < padl) return '0;
    if (k < padl + npix) return 16'(base + k - padl);
    return '0;
  endfunction

  task automatic run_pass(input vec_t v, input string tag);
    int  words, outs, dones, done_cyc, last_out, first_real, last_real, first_glb;
    bit  fin;
    words = 0; outs = 0; dones = 0; done_cyc = -1; last_out = 0;
    first_real = -1; last_real = -1; first_glb = -1; fin = 0;
    @(negedge i_clk);
    i_npix = CNTW'(v.npix);
`ifdef PE_FEEDER_ZPAD_EN
    i_padL = 4'(v.padl);
    i_padR = 4'(v.padr);
`endif
    i_start = 1'b1; GLB_rdy = 1'b0; Input_ack = 1'b0;
    for (int cyc = 1; cyc <= 300 && !fin; cyc++) begin
      @(negedge i_clk);
      i_start   = 1'b0;
      GLB_rdy   = v.glb_mask[cyc % 8];
      Input_ack = (cyc > v.stall) ? v.ack_mask[cyc % 8] : 1'b0;
      GLB_data  = make_word(v.base, words);
      #1;
      if (v.stall > 0 && cyc == v.stall) begin
        check({tag, "_stall_words"}, words, v.exp_stall_words);
        check({tag, "_stall_ack"}, GLB_ack, 0);
        check({tag, "_stall_data"}, Input_data, 16'(v.base));
      end
      if (GLB_rdy && GLB_ack) begin
        if (first_glb < 0) first_glb = cyc;
        words++;
      end
      if (Input_rdy && Input_ack) begin
        check({tag, "_data"}, Input_data, exp_pix(outs, v.base, v.padl, v.npix));
        if (outs >= v.padl && outs < v.padl + v.npix) begin
          if (first_real < 0) first_real = cyc;
          last_real = cyc;
        end
        last_out = cyc;
        outs++;
      end
      if (o_done) begin
        dones++;
        done_cyc = cyc;
        fin = 1;
      end
    end
    if (!fin) check({tag, "_timeout"}, 0, 1);
    check({tag, "_glb_words"}, words, v.exp_words);
    check({tag, "_xfers"}, outs, v.exp_xfers);
    check({tag, "_done_cnt"}, dones, 1);
    check({tag, "_done_lat"}, done_cyc, last_out + 1);
    if (v.nobubble != 0) check({tag, "_nobubble"}, last_real - first_real, v.npix - 1);
    if (v.padl > 0 && v.npix > 0) check({tag, "_prefetch"}, first_glb <= v.padl, 1);
    @(negedge i_clk);
    #1;
    check({tag, "_idle_busy"}, o_busy, 0);
    check({tag, "_idle_done"}, o_done, 0);
  endtask

  task automatic abort_seq();
    int  words, outs;
    bit  hit, done_seen;
    vec_t v;
    words = 0; outs = 0; hit = 0; done_seen = 0;
    @(negedge i_clk);
    i_npix = 8'd8; i_start = 1'b1; GLB_rdy = 1'b1; Input_ack = 1'b1;
    GLB_data = make_word(16'h100, 0);
    for (int c = 0; c < 50 && !hit; c++) begin
      @(negedge i_clk);
      i_start  = 1'b0;
      GLB_data = make_word(16'h100, words);
      #1;
      if (GLB_rdy && GLB_ack) words++;
      if (Input_rdy && Input_ack) outs++;
      if (outs == 3) hit = 1;
    end
    check("abort_reach3", hit, 1);
    @(negedge i_clk);
    i_abort = 1'b1;
    @(negedge i_clk);
    i_abort = 1'b0;
    #1;
    check("abort_busy", o_busy, 0);
    check("abort_glb_ack", GLB_ack, 0);
    check("abort_in_rdy", Input_rdy, 0);
    check("abort_done", o_done, 0);
    repeat (3) begin
      @(negedge i_clk);
      #1;
      if (o_done) done_seen = 1;
    end
    check("abort_no_done", done_seen, 0);
    GLB_rdy = 1'b0; Input_ack = 1'b0;
    v = '{npix:4, base:'h700, glb_mask:'hff, ack_mask:'hff, stall:0,
          padl:0, padr:0, exp_words:1, exp_xfers:4, exp_stall_words:0, nobubble:1};
    run_pass(v, "post_abort");
  endtask

  task automatic reset_seq();
    vec_t v;
    @(negedge i_clk);
    i_npix = 8'd8; i_start = 1'b1; GLB_rdy = 1'b1; Input_ack = 1'b1;
    GLB_data = make_word(16'h300, 0);
    @(negedge i_clk);
    i_start = 1'b0;
    repeat (3) @(negedge i_clk);
    check("rst_pre_busy", o_busy, 1);
    #2;
    i_rst_n = 1'b0;
    #1;
    check("rst_async_glb_ack", GLB_ack, 0);
    check("rst_async_in_rdy", Input_rdy, 0);
    check("rst_async_data", Input_data, 0);
    check("rst_async_busy", o_busy, 0);
    check("rst_async_done", o_done, 0);
    @(negedge i_clk);
    i_rst_n = 1'b1; GLB_rdy = 1'b0; Input_ack = 1'b0;
    v = '{npix:4, base:'h500, glb_mask:'hff, ack_mask:'hff, stall:0,
          padl:0, padr:0, exp_words:1, exp_xfers:4, exp_stall_words:0, nobubble:1};
    run_pass(v, "post_reset");
  endtask

  initial begin
    i_rst_n = 1'b0; i_start = 1'b0; i_abort = 1'b0; i_npix = '0;
`ifdef PE_FEEDER_ZPAD_EN
    i_padL = '0; i_padR = '0;
`endif
    GLB_rdy = 1'b0; GLB_data = '0; Input_ack = 1'b0;
    repeat (3) @(negedge i_clk);
    #1;
    check("reset_glb_ack", GLB_ack, 0);
    check("reset_in_rdy", Input_rdy, 0);
    check("reset_in_data", Input_data, 0);
    check("reset_busy", o_busy, 0);
    check("reset_done", o_done, 0);
    @(negedge i_clk);
    i_rst_n = 1'b1;

    vecs.push_back('{npix:8,  base:'h10,  glb_mask:'hff, ack_mask:'hff, stall:0,  padl:0, padr:0, exp_words:2, exp_xfers:8,  exp_stall_words:0, nobubble:1});
    vecs.push_back('{npix:6,  base:'h40,  glb_mask:'hff, ack_mask:'hff, stall:0,  padl:0, padr:0, exp_words:2, exp_xfers:6,  exp_stall_words:0, nobubble:1});
    vecs.push_back('{npix:8,  base:'h80,  glb_mask:'hff, ack_mask:'hff, stall:20, padl:0, padr:0, exp_words:2, exp_xfers:8,  exp_stall_words:2, nobubble:0});
    vecs.push_back('{npix:5,  base:'hA0,  glb_mask:'ha5, ack_mask:'h6d, stall:0,  padl:0, padr:0, exp_words:2, exp_xfers:5,  exp_stall_words:0, nobubble:0});
    vecs.push_back('{npix:1,  base:'hC3,  glb_mask:'hff, ack_mask:'hff, stall:0,  padl:0, padr:0, exp_words:1, exp_xfers:1,  exp_stall_words:0, nobubble:0});
    vecs.push_back('{npix:0,  base:'hD0,  glb_mask:'hff, ack_mask:'hff, stall:0,  padl:0, padr:0, exp_words:0, exp_xfers:0,  exp_stall_words:0, nobubble:0});
    vecs.push_back('{npix:13, base:'hE00, glb_mask:'hc3, ack_mask:'hff, stall:0,  padl:0, padr:0, exp_words:4, exp_xfers:13, exp_stall_words:0, nobubble:0});
    vecs.push_back('{npix:4,  base:'hF0,  glb_mask:'hff, ack_mask:'hff, stall:0,  padl:0, padr:0, exp_words:1, exp_xfers:4,  exp_stall_words:0, nobubble:1});
`ifdef PE_FEEDER_ZPAD_EN
    vecs.push_back('{npix:4,  base:'h200, glb_mask:'hff, ack_mask:'hff, stall:0,  padl:2, padr:1, exp_words:1, exp_xfers:7,  exp_stall_words:0, nobubble:1});
    vecs.push_back('{npix:0,  base:'h0,   glb_mask:'hff, ack_mask:'hff, stall:0,  padl:1, padr:0, exp_words:0, exp_xfers:1,  exp_stall_words:0, nobubble:0});
    vecs.push_back('{npix:7,  base:'h240, glb_mask:'h5a, ack_mask:'hbb, stall:0,  padl:3, padr:2, exp_words:2, exp_xfers:12, exp_stall_words:0, nobubble:0});
`endif

    for (int i = 0; i < vecs.size(); i++) run_pass(vecs[i], $sformatf("v%0d", i));

    abort_seq();
    reset_seq();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
